aes_dec_sequencer: RTL and testbench

Control sequencer for the AES-128 decryption datapath: message register, round-key mux, and the ARK/ISB/ISR/IMC operation mux. On AES_START it loads the ciphertext, waits for key expansion, then drives operation select, store enable, round-key index and IMC column strobes through the full 10-round inverse cipher. It completes with a DONE/START four-phase handshake. It replaces ad-hoc round/column counting inside the core top level with a single Moore FSM.

---
 rtl/aes_dec_sequencer_if.sv | 24 ++
 rtl/aes_dec_sequencer.sv | 137 +++++++++++++
 tb/tb_aes_dec_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_sequencer_if.sv
// Control bundle between the AES-128 decryption sequencer and its datapath / requester.
// The slave side is the sequencer; the master side drives the start request and observes controls.
interface aes_dec_sequencer_if;
    logic       aes_start;
    logic       load;
    logic [1:0] sel;
    logic       store;
    logic [3:0] key_idx;
    logic [3:0] round;
    logic [1:0] col;
    logic       col_we;
    logic       busy;
    logic       aes_done;

    modport slave (
        input  aes_start,
        output load, sel, store, key_idx, round, col, col_we, busy, aes_done
    );

    modport master (
        output aes_start,
        input  load, sel, store, key_idx, round, col, col_we, busy, aes_done
    );
endinterface

// File: rtl/aes_dec_sequencer.sv
// Moore FSM sequencing the AES-128 inverse cipher: load, key wait, initial ARK,
// nine full rounds (ISR/ISB/ARK/IMC) and a final round without IMC.
module aes_dec_sequencer #(
    parameter int KEY_WAIT_CYCLES = 10,
    parameter int ISB_WAIT        = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    aes_dec_sequencer_if.slave  io_bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_KEY_WAIT, S_ARK_INIT,
        S_R_ISR, S_R_ISB, S_R_ARK, S_R_IMC,
        S_F_ISR, S_F_ISB, S_F_ARK, S_DONE
    } state_t;

    localparam logic [7:0] KW_LAST  = 8'(KEY_WAIT_CYCLES - 1);
    localparam logic [7:0] ISB_LAST = 8'(ISB_WAIT);
    localparam logic [7:0] IMC_LAST = 8'd4;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [3:0] r_round;
    logic [3:0] r_key_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_round   <= 4'd0;
            r_key_idx <= 4'd0;
        end else begin
            r_state <= w_next;
            // Per-state dwell counter restarts on every state change.
            r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;

            if (r_state == S_IDLE && w_next == S_LOAD)
                r_round <= 4'd0;
            else if (r_state == S_ARK_INIT)
                r_round <= 4'd1;
            else if (r_state == S_R_IMC && w_next != S_R_IMC && r_round != 4'd10)
                r_round <= r_round + 4'd1;

            // Key index is latched on ARK entry and held elsewhere.
            case (w_next)
                S_ARK_INIT: r_key_idx <= 4'd10;
                S_R_ARK:    r_key_idx <= 4'd10 - r_round;
                S_F_ARK:    r_key_idx <= 4'd0;
                default:    r_key_idx <= r_key_idx;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        io_bus.load    = 1'b0;
        io_bus.sel     = 2'd0;
        io_bus.store   = 1'b0;
        io_bus.col     = 2'd0;
        io_bus.col_we  = 1'b0;
        io_bus.busy    = 1'b1;
        io_bus.aes_done = 1'b0;
        io_bus.key_idx = r_key_idx;
        io_bus.round   = r_round;

        case (r_state)
            S_IDLE: begin
                io_bus.busy = 1'b0;
                if (io_bus.aes_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                io_bus.load = 1'b1;
                w_next = (KEY_WAIT_CYCLES == 0) ? S_ARK_INIT : S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (r_cnt == KW_LAST) w_next = S_ARK_INIT;
            end
            S_ARK_INIT: begin
                io_bus.store = 1'b1;
                w_next = S_R_ISR;
            end
            S_R_ISR: begin
                io_bus.sel   = 2'd2;
                io_bus.store = 1'b1;
                w_next = S_R_ISB;
            end
            S_R_ISB: begin
                io_bus.sel = 2'd1;
                if (r_cnt == ISB_LAST) begin
                    io_bus.store = 1'b1;
                    w_next = S_R_ARK;
                end
            end
            S_R_ARK: begin
                io_bus.store = 1'b1;
                w_next = S_R_IMC;
            end
            S_R_IMC: begin
                io_bus.sel = 2'd3;
                // Four column strobes, then one store of the concatenated columns.
                if (r_cnt == IMC_LAST) begin
                    io_bus.store = 1'b1;
                    w_next = (r_round == 4'd9) ? S_F_ISR : S_R_ISR;
                end else begin
                    io_bus.col    = r_cnt[1:0];
                    io_bus.col_we = 1'b1;
                end
            end
            S_F_ISR: begin
                io_bus.sel   = 2'd2;
                io_bus.store = 1'b1;
                w_next = S_F_ISB;
            end
            S_F_ISB: begin
                io_bus.sel = 2'd1;
                if (r_cnt == ISB_LAST) begin
                    io_bus.store = 1'b1;
                    w_next = S_F_ARK;
                end
            end
            S_F_ARK: begin
                io_bus.store = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                io_bus.busy     = 1'b0;
                io_bus.aes_done = 1'b1;
                if (!io_bus.aes_start) w_next = S_IDLE;
            end
            default: begin
                io_bus.busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Directed bench: default-parameter sequencer plus a KEY_WAIT_CYCLES=0 / ISB_WAIT=2 instance.
module tb_aes_dec_sequencer;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aes_dec_sequencer_if if0();
    aes_dec_sequencer_if if1();

    aes_dec_sequencer u_dut0 (
        .i_clk   (clk),
        .i_reset (rst0),
        .io_bus  (if0.slave)
    );

    aes_dec_sequencer #(.KEY_WAIT_CYCLES(0), .ISB_WAIT(2)) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .io_bus  (if1.slave)
    );

    typedef struct packed {
        logic       load;
        logic       store;
        logic       col_we;
        logic       busy;
        logic       done;
        logic [1:0] sel;
        logic [1:0] col;
        logic [3:0] kidx;
        logic [3:0] rnd;
    } snap_t;

    // Block statistics gathered by run_block
    int         g_done_e, g_store, g_colwe, g_load, g_col_bad;
    int         g_isb_min, g_isb_max, g_isb_n, g_kn;
    logic       g_store_e1;
    logic [3:0] g_done_rnd;
    logic [3:0] g_kq [0:15];

    function automatic snap_t snap(input int d);
        snap_t s;
        if (d == 0) begin
            s.load = if0.load; s.store = if0.store; s.col_we = if0.col_we; s.busy = if0.busy;
            s.done = if0.aes_done; s.sel = if0.sel; s.col = if0.col; s.kidx = if0.key_idx; s.rnd = if0.round;
        end else begin
            s.load = if1.load; s.store = if1.store; s.col_we = if1.col_we; s.busy = if1.busy;
            s.done = if1.aes_done; s.sel = if1.sel; s.col = if1.col; s.kidx = if1.key_idx; s.rnd = if1.round;
        end
        return s;
    endfunction

    task automatic drive_start(input int d, input logic v);
        if (d == 0) if0.aes_start = v;
        else        if1.aes_start = v;
    endtask

    // Raise start at a negedge; edge e is the e-th posedge after that (edge 0 samples start).
    task automatic run_block(input int d, input bit hold);
        snap_t s;
        int run;
        run = 0;
        g_done_e = -1; g_store = 0; g_colwe = 0; g_load = 0; g_col_bad = 0;
        g_isb_min = 999; g_isb_max = -1; g_isb_n = 0; g_kn = 0;
        g_store_e1 = 1'bx; g_done_rnd = 4'hx;
        drive_start(d, 1'b1);
        for (int e = 0; e < 200; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0 && !hold) drive_start(d, 1'b0);
            s = snap(d);
            if (e == 1) g_store_e1 = s.store;
            if (s.load) g_load++;
            if (s.store) g_store++;
            if (s.col_we) g_colwe++;
            if (!s.col_we && s.col != 2'd0) g_col_bad++;
            if (s.sel == 2'd1 && s.busy && !s.store) run++;
            else if (s.sel == 2'd1 && s.store) begin
                if (run < g_isb_min) g_isb_min = run;
                if (run > g_isb_max) g_isb_max = run;
                g_isb_n++;
                run = 0;
            end
            if (s.store && s.sel == 2'd0 && s.busy && g_kn < 16) begin
                g_kq[g_kn] = s.kidx;
                g_kn++;
            end
            if (s.done) begin
                g_done_e = e;
                g_done_rnd = s.rnd;
                break;
            end
        end
    endtask

    task automatic test_reset;
        snap_t s;
        @(negedge clk);
        rst0 = 1'b1;
        if0.aes_start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            s = snap(0);
            n_checks++;
            if (s !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h expected 0", s);
            end
        end
        rst0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s = snap(0);
        n_checks++;
        if (s.load !== 1'b1 || s.busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_load: load=%b busy=%b expected 1 1", s.load, s.busy);
        end
        @(posedge clk);
        @(negedge clk);
        s = snap(0);
        n_checks++;
        if (s.load !== 1'b0) begin
            n_err++;
            $display("FAIL load_one_cycle: load=%b expected 0", s.load);
        end
        rst0 = 1'b1;
        if0.aes_start = 1'b0;
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_block;
        run_block(0, 1'b0);
        n_checks++;
        if (g_done_e != 97) begin n_err++; $display("FAIL def_done_edge: got %0d expected 97", g_done_e); end
        n_checks++;
        if (g_store != 40) begin n_err++; $display("FAIL def_store_count: got %0d expected 40", g_store); end
        n_checks++;
        if (g_colwe != 36) begin n_err++; $display("FAIL def_colwe_count: got %0d expected 36", g_colwe); end
        n_checks++;
        if (g_load != 1) begin n_err++; $display("FAIL def_load_count: got %0d expected 1", g_load); end
        n_checks++;
        if (g_col_bad != 0) begin n_err++; $display("FAIL def_col_idle_zero: got %0d bad cycles expected 0", g_col_bad); end
        n_checks++;
        if (g_store_e1 !== 1'b0) begin n_err++; $display("FAIL def_keywait_nostore: got %b expected 0", g_store_e1); end
        n_checks++;
        if (g_isb_n != 10 || g_isb_min != 1 || g_isb_max != 1) begin
            n_err++;
            $display("FAIL def_isb_wait: n=%0d min=%0d max=%0d expected 10 1 1", g_isb_n, g_isb_min, g_isb_max);
        end
        n_checks++;
        if (g_kn != 11) begin n_err++; $display("FAIL def_ark_count: got %0d expected 11", g_kn); end
        for (int k = 0; k < 11 && k < g_kn; k++) begin
            n_checks++;
            if (g_kq[k] !== 4'(10 - k)) begin
                n_err++;
                $display("FAIL def_key_idx[%0d]: got %0d expected %0d", k, g_kq[k], 10 - k);
            end
        end
        n_checks++;
        if (g_done_rnd !== 4'd10) begin n_err++; $display("FAIL def_round_at_done: got %0d expected 10", g_done_rnd); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_params;
        @(negedge clk);
        rst1 = 1'b0;
        if1.aes_start = 1'b0;
        @(negedge clk);
        run_block(1, 1'b0);
        n_checks++;
        if (g_done_e != 97) begin n_err++; $display("FAIL par_done_edge: got %0d expected 97", g_done_e); end
        n_checks++;
        if (g_store_e1 !== 1'b1) begin n_err++; $display("FAIL par_no_keywait: store after edge1=%b expected 1", g_store_e1); end
        n_checks++;
        if (g_isb_n != 10 || g_isb_min != 2 || g_isb_max != 2) begin
            n_err++;
            $display("FAIL par_isb_wait: n=%0d min=%0d max=%0d expected 10 2 2", g_isb_n, g_isb_min, g_isb_max);
        end
        n_checks++;
        if (g_store != 40 || g_colwe != 36) begin
            n_err++;
            $display("FAIL par_pulse_counts: store=%0d colwe=%0d expected 40 36", g_store, g_colwe);
        end
        n_checks++;
        if (g_kn != 11 || g_kq[0] !== 4'd10 || g_kq[10] !== 4'd0) begin
            n_err++;
            $display("FAIL par_key_idx: n=%0d first=%0d last=%0d expected 11 10 0", g_kn, g_kq[0], g_kq[10]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_handshake;
        snap_t s;
        int done_n, load_n;
        done_n = 0;
        load_n = 0;
        run_block(0, 1'b1);
        n_checks++;
        if (g_done_e != 97) begin n_err++; $display("FAIL hs_done_edge: got %0d expected 97", g_done_e); end
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            s = snap(0);
            if (s.done) done_n++;
            if (s.load) load_n++;
        end
        n_checks++;
        if (done_n != 20 || load_n != 0) begin
            n_err++;
            $display("FAIL hs_hold_done: done=%0d load=%0d expected 20 0", done_n, load_n);
        end
        if0.aes_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s = snap(0);
        n_checks++;
        if (s.done !== 1'b0 || s.busy !== 1'b0 || s.load !== 1'b0) begin
            n_err++;
            $display("FAIL hs_to_idle: done=%b busy=%b load=%b expected 0 0 0", s.done, s.busy, s.load);
        end
        if0.aes_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = snap(0);
        n_checks++;
        if (s.load !== 1'b1) begin n_err++; $display("FAIL hs_restart_load: got %b expected 1", s.load); end
        if0.aes_start = 1'b0;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        snap_t s;
        bit found;
        found = 1'b0;
        if0.aes_start = 1'b1;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0) if0.aes_start = 1'b0;
            s = snap(0);
            if (s.rnd == 4'd5 && s.sel == 2'd3 && s.col_we && s.col == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin n_err++; $display("FAIL mid_reach_r5_col2: got 0 expected 1"); end
        rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = snap(0);
        n_checks++;
        if (s !== '0) begin n_err++; $display("FAIL mid_reset_outputs: got %h expected 0", s); end
        rst0 = 1'b0;
        run_block(0, 1'b0);
        n_checks++;
        if (g_done_e != 97 || g_store != 40) begin
            n_err++;
            $display("FAIL mid_rerun: done_edge=%0d stores=%0d expected 97 40", g_done_e, g_store);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        if0.aes_start = 1'b0;
        if1.aes_start = 1'b0;
        test_reset();
        test_full_block();
        test_params();
        test_handshake();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
